// File: rtl/multiword_add_seq.sv
// multiword_add_seq: word-serial wide adder/subtractor.
//
// Two Width*NumWords-bit operands are added (or subtracted) one Width-bit
// word per cycle, least-significant word first. A single prefix carry
// network is shared across all words, and the carry between words is held
// in a register.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  synchronous abort of the current operation
//   req_valid_i/req_ready_o  request handshake (a_i, b_i, sub_i, ci_i)
//   rsp_valid_o/rsp_ready_i  response handshake (sum_o, co_o, ovf_o)
//   busy_o                   high while an operation is running or held
//   zero_o                   result-is-zero flag, present only when
//                            ELAU_MWADD_ZERO_FLAG_EN is defined
//
// Speed selects the prefix structure: FAST = Kogge-Stone,
// MEDIUM = Sklansky, SLOW = serial (ripple) prefix.
//
// state | meaning
// IDLE  | ready for a request; outputs hold the last result
// RUN   | processing word cnt_q; one word per cycle
// DONE  | result valid; waiting for rsp_ready_i

package lau_pkg;
   typedef enum logic [1:0] {FAST, MEDIUM, SLOW} speed_e;
endpackage

module multiword_add_seq #(
   parameter int              Width    = 16,
   parameter int              NumWords = 4,
   parameter lau_pkg::speed_e Speed    = lau_pkg::FAST
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [Width*NumWords-1:0] a_i,
   input  logic [Width*NumWords-1:0] b_i,
   input  logic                      sub_i,
   input  logic                      ci_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [Width*NumWords-1:0] sum_o,
   output logic                      co_o,
   output logic                      ovf_o,
   output logic                      busy_o
`ifdef ELAU_MWADD_ZERO_FLAG_EN
   ,
   output logic                      zero_o
`endif
);

   localparam int TotW = Width * NumWords;
   localparam int CntW = (NumWords > 1) ? $clog2(NumWords) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q;
   logic              carry_q;
   logic [TotW-1:0]   a_q, b_q, sum_q;
   logic              co_q, ovf_q;
   logic              accept, last_word;
   logic [Width-1:0]  a_w, b_w, g_w, p_w, g0_w;
   logic [Width-1:0]  gk, pk, gn, pn, c_pfx, sum_w;

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign sum_o       = sum_q;
   assign co_o        = co_q;
   assign ovf_o       = ovf_q;

   // flush_i wins over a simultaneous request handshake
   assign accept    = req_valid_i & req_ready_o & ~flush_i;
   assign last_word = (cnt_q == CntW'(NumWords - 1));

   assign a_w = a_q[cnt_q*Width +: Width];
   assign b_w = b_q[cnt_q*Width +: Width];

   always_comb begin
      g_w     = a_w & b_w;
      p_w     = a_w ^ b_w;
      g0_w    = g_w;
      // fold the inter-word carry into bit 0 so the network needs no carry-in
      g0_w[0] = g_w[0] | (p_w[0] & carry_q);
   end

   always_comb begin
      gk = g0_w;
      pk = p_w;
      gn = gk;
      pn = pk;
      if (Speed == lau_pkg::SLOW) begin
         for (int i = 1; i < Width; i++) begin
            gk[i] = gk[i] | (pk[i] & gk[i-1]);
         end
      end else if (Speed == lau_pkg::MEDIUM) begin
         for (int d = 1; d < Width; d = d * 2) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < Width; i++) begin
               // upper half of each 2d block combines with the top of the lower half
               if (((i / d) % 2) == 1) begin
                  gn[i] = gk[i] | (pk[i] & gk[(i/d)*d-1]);
                  pn[i] = pk[i] & pk[(i/d)*d-1];
               end
            end
            gk = gn;
            pk = pn;
         end
      end else begin
         for (int d = 1; d < Width; d = d * 2) begin
            gn = gk;
            pn = pk;
            for (int i = d; i < Width; i++) begin
               gn[i] = gk[i] | (pk[i] & gk[i-d]);
               pn[i] = pk[i] & pk[i-d];
            end
            gk = gn;
            pk = pn;
         end
      end
      c_pfx = gk;
   end

   assign sum_w = p_w ^ {c_pfx[Width-2:0], carry_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_word) state_d = DONE;
         DONE:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (flush_i) begin
         cnt_q <= '0;
      end else if (accept) begin
         a_q     <= a_i;
         b_q     <= sub_i ? ~b_i : b_i;
         carry_q <= sub_i ? 1'b1 : ci_i;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[cnt_q*Width +: Width] <= sum_w;
         carry_q <= c_pfx[Width-1];
         cnt_q   <= last_word ? '0 : cnt_q + 1'b1;
         if (last_word) begin
            co_q  <= c_pfx[Width-1];
            ovf_q <= c_pfx[Width-1] ^ c_pfx[Width-2];
         end
      end
   end

`ifdef ELAU_MWADD_ZERO_FLAG_EN
   logic zero_q;

   assign zero_o = zero_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         zero_q <= 1'b1;
      end else if (!flush_i) begin
         if (accept) zero_q <= 1'b1;
         else if (state_q == RUN) zero_q <= zero_q & (sum_w == '0);
      end
   end
`endif

endmodule
